// File: rtl/sparc_ram_loader.sv
// sparc_ram_loader
// -----------------------------------------------------------------------------
// Streaming RAM preload engine for the SPARC MPU memory port. It takes a byte
// stream, packs the bytes big-endian into byte, halfword or word units, and
// writes each unit over the MFA/MOC handshake. An optional read-back verifies
// each unit after it is written.
//
// Ports:
//   Clk, Clr             clock, asynchronous active-low reset
//   Start                one-cycle session start (sampled in IDLE only)
//   BaseAddr, Mode       first byte address and unit size (00 B, 01 H, 10 W)
//   In_Data/Valid/Last   byte stream in; In_Ready shows a byte is accepted
//   Mem_Addr/Data/Type   RAM request; Mem_MOV = MFA, Mem_RW 0 write / 1 read
//   Mem_DataIn, MOC      RAM read data and operation-complete
//   Busy, Done, Err      session status; Err is sticky until the next Start
//   ErrCode              01 align/mode, 10 MOC timeout, 11 verify mismatch
//   Count                units written in the current session (saturating)
// -----------------------------------------------------------------------------
module sparc_ram_loader #(
    parameter int unsigned AW      = 9,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned VERIFY  = 0
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          Start,
    input  logic [AW-1:0] BaseAddr,
    input  logic [1:0]    Mode,
    input  logic [7:0]    In_Data,
    input  logic          In_Valid,
    input  logic          In_Last,
    output logic          In_Ready,
    output logic [AW-1:0] Mem_Addr,
    output logic [31:0]   Mem_Data,
    output logic [1:0]    Mem_Type,
    output logic          Mem_MOV,
    output logic          Mem_RW,
    input  logic [31:0]   Mem_DataIn,
    input  logic          MOC,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [1:0]    ErrCode,
    output logic [AW:0]   Count
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [AW:0] CountMax = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CountOne = (AW+1)'(1);

    typedef enum logic [2:0] {
        StIdle, StCollect, StWrite, StRelease, StRead, StCheck, StDone, StErr
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    mode_q, mode_d;
    logic [31:0]   unit_q, unit_d;
    logic [2:0]    nbytes_q, nbytes_d;
    logic          last_q, last_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [1:0]    errcode_q, errcode_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [2:0]  unit_bytes;
    logic [31:0] unit_mask;
    logic [1:0]  byte_pos;
    logic        start_bad;
    logic        tmo_hit;
    logic        advance;
    logic        fail;
    logic [1:0]  fail_code;

    // Unit geometry from the latched mode; 11 is never latched.
    always_comb begin
        unit_bytes = 3'd4;
        unit_mask  = 32'hffff_ffff;
        if (mode_q == 2'b00) begin
            unit_bytes = 3'd1;
            unit_mask  = 32'h0000_00ff;
        end else if (mode_q == 2'b01) begin
            unit_bytes = 3'd2;
            unit_mask  = 32'h0000_ffff;
        end
    end

    // First byte of a unit lands in its most significant byte.
    assign byte_pos  = 2'(unit_bytes - 3'd1 - nbytes_q);
    assign start_bad = (Mode == 2'b11) ||
                       (Mode == 2'b01 && BaseAddr[0]) ||
                       (Mode == 2'b10 && (BaseAddr[1:0] != 2'b00));
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            mode_q    <= '0;
            unit_q    <= '0;
            nbytes_q  <= '0;
            last_q    <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            errcode_q <= '0;
            rdata_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            unit_q    <= unit_d;
            nbytes_q  <= nbytes_d;
            last_q    <= last_d;
            count_q   <= count_d;
            err_q     <= err_d;
            errcode_q <= errcode_d;
            rdata_q   <= rdata_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        unit_d    = unit_q;
        nbytes_d  = nbytes_q;
        last_d    = last_q;
        count_d   = count_q;
        err_d     = err_q;
        errcode_d = errcode_q;
        rdata_d   = rdata_q;
        advance   = 1'b0;
        fail      = 1'b0;
        fail_code = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    err_d     = 1'b0;
                    errcode_d = 2'b00;
                    if (start_bad) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end else begin
                        addr_d   = BaseAddr;
                        mode_d   = Mode;
                        count_d  = '0;
                        unit_d   = '0;
                        nbytes_d = '0;
                        last_d   = 1'b0;
                        state_d  = StCollect;
                    end
                end
            end
            StCollect: begin
                if (In_Valid) begin
                    unit_d[{byte_pos, 3'b000} +: 8] = In_Data;
                    nbytes_d = nbytes_q + 3'd1;
                    last_d   = In_Last;
                    if ((nbytes_q + 3'd1 == unit_bytes) || In_Last) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (MOC) begin
                    if (count_q != CountMax) begin
                        count_d = count_q + CountOne;
                    end
                    state_d = StRelease;
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            StRelease: begin
                // MOC must fall before the next request is issued.
                if (!MOC) begin
                    if (VERIFY != 0) begin
                        state_d = StRead;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            StRead: begin
                if (MOC) begin
                    rdata_d = Mem_DataIn;
                    state_d = StCheck;
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            StCheck: begin
                if (!MOC) begin
                    if ((rdata_q & unit_mask) != unit_q) begin
                        fail      = 1'b1;
                        fail_code = 2'b11;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Unit fully committed: finish the session or open the next unit.
        if (advance) begin
            if (last_q) begin
                state_d = StDone;
            end else begin
                addr_d   = addr_q + AW'(unit_bytes);
                unit_d   = '0;
                nbytes_d = '0;
                state_d  = StCollect;
            end
        end

        if (fail) begin
            err_d     = 1'b1;
            errcode_d = fail_code;
            state_d   = StErr;
        end

        // Restarts on every state change, so each timed phase starts at zero.
        tmo_d = (state_d != state_q) ? '0 : tmo_q + TW'(1);
    end

    // Output decode
    always_comb begin
        In_Ready = 1'b0;
        Mem_MOV  = 1'b0;
        Mem_RW   = 1'b0;
        Busy     = 1'b1;
        Done     = 1'b0;
        unique case (state_q)
            StIdle:    Busy = 1'b0;
            StCollect: In_Ready = 1'b1;
            StWrite:   Mem_MOV = 1'b1;
            StRead: begin
                Mem_MOV = 1'b1;
                Mem_RW  = 1'b1;
            end
            StDone: begin
                Busy = 1'b0;
                Done = 1'b1;
            end
            StErr:   Busy = 1'b0;
            default: ;
        endcase
    end

    assign Mem_Addr = addr_q;
    assign Mem_Data = unit_q;
    assign Mem_Type = mode_q;
    assign Err      = err_q;
    assign ErrCode  = errcode_q;
    assign Count    = count_q;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// tb_sparc_ram_loader
// Directed bench for sparc_ram_loader: one instance without read-back verify
// and one with it, sharing a byte-addressed RAM model selected by 'sel'.
module tb_sparc_ram_loader;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [8:0]  base = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        moc;
    logic [31:0] rdata = '0;
    logic        sel = 1'b0;
    logic        stall = 1'b0;
    logic        corrupt = 1'b0;

    logic [1:0]  ready, mov, rw, busy, done, err;
    logic [8:0]  maddr [2];
    logic [31:0] mdata [2];
    logic [1:0]  mtype [2];
    logic [1:0]  ecode [2];
    logic [9:0]  cnt   [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    sparc_ram_loader #(.AW(9), .TIMEOUT(15), .VERIFY(0)) dut (
        .Clk(Clk), .Clr(Clr), .Start(start[0]), .BaseAddr(base), .Mode(mode),
        .In_Data(in_data), .In_Valid(in_valid), .In_Last(in_last), .In_Ready(ready[0]),
        .Mem_Addr(maddr[0]), .Mem_Data(mdata[0]), .Mem_Type(mtype[0]), .Mem_MOV(mov[0]),
        .Mem_RW(rw[0]), .Mem_DataIn(rdata), .MOC(sel ? 1'b0 : moc), .Busy(busy[0]),
        .Done(done[0]), .Err(err[0]), .ErrCode(ecode[0]), .Count(cnt[0])
    );

    sparc_ram_loader #(.AW(9), .TIMEOUT(15), .VERIFY(1)) dut_v (
        .Clk(Clk), .Clr(Clr), .Start(start[1]), .BaseAddr(base), .Mode(mode),
        .In_Data(in_data), .In_Valid(in_valid), .In_Last(in_last), .In_Ready(ready[1]),
        .Mem_Addr(maddr[1]), .Mem_Data(mdata[1]), .Mem_Type(mtype[1]), .Mem_MOV(mov[1]),
        .Mem_RW(rw[1]), .Mem_DataIn(rdata), .MOC(sel ? moc : 1'b0), .Busy(busy[1]),
        .Done(done[1]), .Err(err[1]), .ErrCode(ecode[1]), .Count(cnt[1])
    );

    // View of the selected instance
    logic        r_mov, r_rw, r_ready, r_busy, r_done, r_err;
    logic [8:0]  r_addr;
    logic [31:0] r_data, wd, rd;
    logic [1:0]  r_type;
    assign r_mov   = mov[sel];
    assign r_rw    = rw[sel];
    assign r_ready = ready[sel];
    assign r_busy  = busy[sel];
    assign r_done  = done[sel];
    assign r_err   = err[sel];
    assign r_addr  = maddr[sel];
    assign r_data  = mdata[sel];
    assign r_type  = mtype[sel];

    // RAM model: MOC the cycle after MOV, low the cycle after MOV falls.
    logic [7:0]  mem [512];
    int          wr_n = 0;
    logic [8:0]  wr_addr [32];
    logic [31:0] wr_data [32];
    logic [1:0]  wr_type [32];

    assign wd = (corrupt && r_addr == 9'h020) ? (r_data ^ 32'h1) : r_data;
    assign rd = (r_type == 2'b00) ? {24'h0, mem[r_addr]} :
                (r_type == 2'b01) ? {16'h0, mem[r_addr], mem[r_addr + 9'd1]} :
                {mem[r_addr], mem[r_addr + 9'd1], mem[r_addr + 9'd2], mem[r_addr + 9'd3]};

    always @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            moc <= 1'b0;
        end else if (r_mov && !moc && !stall) begin
            moc <= 1'b1;
            if (!r_rw) begin
                case (r_type)
                    2'b00: mem[r_addr] <= wd[7:0];
                    2'b01: begin
                        mem[r_addr]        <= wd[15:8];
                        mem[r_addr + 9'd1] <= wd[7:0];
                    end
                    default: begin
                        mem[r_addr]        <= wd[31:24];
                        mem[r_addr + 9'd1] <= wd[23:16];
                        mem[r_addr + 9'd2] <= wd[15:8];
                        mem[r_addr + 9'd3] <= wd[7:0];
                    end
                endcase
                wr_addr[wr_n[4:0]] <= r_addr;
                wr_data[wr_n[4:0]] <= r_data;
                wr_type[wr_n[4:0]] <= r_type;
                wr_n <= wr_n + 1;
            end else begin
                rdata <= rd;
            end
        end else if (!r_mov) begin
            moc <= 1'b0;
        end
    end

    // Event monitor, sampled away from the active edge
    int   cyc = 0, rise_t = 0, fall_t = 0, mov_rises = 0, ready_cnt = 0, done_cnt = 0;
    logic prev_mov = 1'b0;
    always @(negedge Clk) begin
        cyc      <= cyc + 1;
        prev_mov <= r_mov;
        if (r_mov && !prev_mov) begin
            rise_t    <= cyc;
            mov_rises <= mov_rises + 1;
        end
        if (!r_mov && prev_mov) fall_t <= cyc;
        if (r_ready) ready_cnt <= ready_cnt + 1;
        if (r_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] a, input logic [1:0] m);
        @(negedge Clk);
        base = a;
        mode = m;
        start[sel] = 1'b1;
        @(negedge Clk);
        start = 2'b00;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge Clk);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        while (!r_ready && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) check("send_ready", 32'(r_ready), 32'd1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int t = 0;
        while (!r_done && !(r_err && !r_busy) && t < 300) begin
            @(negedge Clk);
            t++;
        end
        check(tag, 32'(t < 300), 32'd1);
        @(negedge Clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap_mov, snap_rdy, snap_done, wb, t;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_busy", 32'(r_busy), 0);
        check("rst_ready", 32'(r_ready), 0);
        check("rst_mov", 32'(r_mov), 0);
        check("rst_count", 32'(cnt[0]), 0);
        Clr = 1'b1;
        @(negedge Clk);

        // Byte mode, base 0x000
        snap_done = done_cnt;
        do_start(9'h000, 2'b00);
        check("b_busy", 32'(r_busy), 1);
        send_byte(8'h8A, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        wait_end("b_end");
        check("b_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h8A00_1234);
        check("b_count", 32'(cnt[0]), 4);
        check("b_done", 32'(done_cnt - snap_done), 1);
        check("b_err", 32'(r_err), 0);
        check("b_busy_end", 32'(r_busy), 0);

        // Word mode, base 0x010, trailing partial unit padded
        wb = wr_n;
        do_start(9'h010, 2'b10);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h01, 1'b1);
        wait_end("w_end");
        check("w_addr0", 32'(wr_addr[wb]), 32'h010);
        check("w_data0", wr_data[wb], 32'hDEAD_BEEF);
        check("w_type0", 32'(wr_type[wb]), 2);
        check("w_addr1", 32'(wr_addr[wb + 1]), 32'h014);
        check("w_data1", wr_data[wb + 1], 32'h0100_0000);
        check("w_count", 32'(cnt[0]), 2);

        // Halfword mode, base 0x040, odd byte count
        wb = wr_n;
        do_start(9'h040, 2'b01);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_end("h_end");
        check("h_data0", wr_data[wb], 32'h0000_1122);
        check("h_addr1", 32'(wr_addr[wb + 1]), 32'h042);
        check("h_data1", wr_data[wb + 1], 32'h0000_3300);
        check("h_mem", {mem[9'h40], mem[9'h41], mem[9'h42], mem[9'h43]}, 32'h1122_3300);

        // Misaligned halfword start
        snap_mov = mov_rises;
        snap_rdy = ready_cnt;
        do_start(9'h003, 2'b01);
        repeat (3) @(negedge Clk);
        check("mis_err", 32'(r_err), 1);
        check("mis_code", 32'(ecode[0]), 1);
        check("mis_mov", 32'(mov_rises - snap_mov), 0);
        check("mis_ready", 32'(ready_cnt - snap_rdy), 0);
        check("mis_busy", 32'(r_busy), 0);

        // Illegal mode 11
        do_start(9'h000, 2'b11);
        repeat (2) @(negedge Clk);
        check("ill_code", 32'(ecode[0]), 1);

        // MOC never arrives: timeout
        stall = 1'b1;
        do_start(9'h030, 2'b00);
        check("to_clr_err", 32'(r_err), 0);
        send_byte(8'h55, 1'b1);
        wait_end("to_end");
        @(negedge Clk);
        check("to_width", 32'(fall_t - rise_t), 15);
        check("to_err", 32'(r_err), 1);
        check("to_code", 32'(ecode[0]), 2);
        check("to_mov", 32'(r_mov), 0);
        stall = 1'b0;
        do_start(9'h000, 2'b00);
        check("restart_err", 32'(r_err), 0);
        check("restart_code", 32'(ecode[0]), 0);
        send_byte(8'h66, 1'b1);
        wait_end("restart_end");
        check("restart_mem", 32'(mem[0]), 32'h66);

        // Verify instance: clean read-back, then corrupted write
        sel = 1'b1;
        snap_done = done_cnt;
        do_start(9'h024, 2'b10);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        wait_end("v_end");
        check("v_done", 32'(done_cnt - snap_done), 1);
        check("v_err", 32'(r_err), 0);
        check("v_count", 32'(cnt[1]), 1);
        corrupt = 1'b1;
        wb = wr_n;
        do_start(9'h020, 2'b10);
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h0D, 1'b1);
        wait_end("vx_end");
        check("vx_wdata", wr_data[wb], 32'hCAFE_F00D);
        check("vx_err", 32'(r_err), 1);
        check("vx_code", 32'(ecode[1]), 3);
        check("vx_count", 32'(cnt[1]), 1);
        corrupt = 1'b0;
        sel = 1'b0;

        // Address wrap at the top of the byte space
        wb = wr_n;
        do_start(9'h1FF, 2'b00);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        wait_end("wrap_end");
        check("wrap_addr0", 32'(wr_addr[wb]), 32'h1FF);
        check("wrap_addr1", 32'(wr_addr[wb + 1]), 32'h000);
        check("wrap_mem", {mem[9'h1FF], mem[0]}, 32'hAABB);
        check("wrap_err", 32'(r_err), 0);

        // Reset in the middle of a write
        stall = 1'b1;
        do_start(9'h050, 2'b00);
        send_byte(8'h77, 1'b1);
        t = 0;
        while (!r_mov && t < 20) begin
            @(negedge Clk);
            t++;
        end
        check("mid_mov", 32'(r_mov), 1);
        #2;
        Clr = 1'b0;
        #1;
        check("arst_mov", 32'(r_mov), 0);
        check("arst_busy", 32'(r_busy), 0);
        check("arst_ready", 32'(r_ready), 0);
        check("arst_done", 32'(r_done), 0);
        check("arst_count", 32'(cnt[0]), 0);
        check("arst_addr", 32'(maddr[0]), 0);
        check("arst_data", mdata[0], 0);
        check("arst_type", 32'(mtype[0]), 0);
        check("arst_err", {30'h0, err[0], 1'b0} | 32'(ecode[0]), 0);
        @(negedge Clk);
        stall = 1'b0;
        Clr = 1'b1;
        repeat (2) @(negedge Clk);
        check("post_rst_busy", 32'(r_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sparc_ram_loader.md
Name: sparc_ram_loader

Overview:
- Hardware RAM preload engine for the SPARC MPU memory port; replaces bench-side poking of MAR/MDR/mov with a synthesizable streaming loader.
- Accepts a byte stream (valid/ready), packs bytes big-endian into byte, halfword or word units, and writes each unit to RAM over the MFA/MOC handshake.
- Optional read-back verify per unit.
- Sits between a boot/program source (UART, ROM, testbench file reader) and the RAM port, muxed ahead of the control unit during preload.

Parameters:
- AW, 9, RAM address width in bytes.
- TIMEOUT, 15, maximum cycles to wait for MOC in any memory phase before error (≥1).
- VERIFY, 0, when 1, each written unit is read back and compared.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Clr  in  1  reset, asynchronous, active-low.
- Start  in  1  one-cycle pulse; begins a load session; sampled only in IDLE.
- BaseAddr  in  AW  first byte address, sampled on Start.
- Mode  in  2  unit size, sampled on Start: 00 byte, 01 halfword, 10 word; 11 is illegal.
- In_Data  in  8  stream byte.
- In_Valid  in  1  In_Data valid.
- In_Last  in  1  marks the final byte of the session; qualified by In_Valid.
- In_Ready  out  1  loader accepts a byte this cycle.
- Mem_Addr  out  AW  RAM byte address.
- Mem_Data  out  32  write data, right-justified.
- Mem_Type  out  2  size code to RAM, equal to the latched Mode.
- Mem_MOV  out  1  memory function active (MFA).
- Mem_RW  out  1  0 = write, 1 = read.
- Mem_DataIn  in  32  read data from RAM, right-justified.
- MOC  in  1  memory operation complete.
- Busy  out  1  session in progress.
- Done  out  1  one-cycle pulse when the session ends cleanly.
- Err  out  1  sticky error flag; cleared by the next accepted Start or by reset.
- ErrCode  out  2  01 misaligned or illegal mode, 10 MOC timeout, 11 verify mismatch.
- Count  out  AW+1  units written in the current session.

Behaviour:
- Reset (Clr=0, asynchronous): state IDLE. All outputs 0 (In_Ready, Mem_*, Busy, Done, Err, ErrCode, Count). Reset mid-transaction drops Mem_MOV immediately and discards any partial unit.
- States: IDLE, COLLECT, WRITE, RELEASE, READ, CHECK, DONE, ERR.
- IDLE + Start:
  - BaseAddr not aligned to the unit size, or Mode=11 → ERR with ErrCode=01.
  - Otherwise latch BaseAddr/Mode, clear Count, Err and ErrCode, and go to COLLECT.
  - Start outside IDLE is ignored.
- COLLECT:
  - In_Ready=1. A byte is taken when In_Valid && In_Ready.
  - The first byte of a unit goes to the most significant byte of that unit.
  - When the unit holds 1, 2 or 4 bytes (per Mode), or In_Last is taken, go to WRITE on the next cycle.
  - A partial unit closed by In_Last is padded with 0x00 in its low bytes.
- WRITE:
  - Mem_MOV=1, Mem_RW=0. Mem_Addr and Mem_Data are held stable for the whole phase.
  - On the first cycle MOC=1 is sampled: Count+1, then go to RELEASE.
- RELEASE:
  - Mem_MOV=0; wait for MOC=0 before any new request (MOC is never assumed to self-clear).
  - After MOC=0: go to READ if VERIFY=1; otherwise go to DONE if the unit held In_Last, else advance the address and go to COLLECT.
- READ / CHECK:
  - READ asserts Mem_MOV=1, Mem_RW=1 at the same address; on MOC=1, latch Mem_DataIn and go to CHECK.
  - CHECK waits for MOC=0 and compares the latched data to the written unit, masked to the unit width.
  - Mismatch → ERR with ErrCode=11. Match → continue exactly as the RELEASE exit.
- Address advance: Mem_Addr += 1, 2 or 4 for byte, halfword or word, modulo 2^AW. Wrap is silent, not an error.
- Timeout: a counter clears on entry to WRITE, RELEASE, READ and CHECK and counts cycles in that state. Reaching TIMEOUT before the awaited MOC level → ERR with ErrCode=10 and Mem_MOV=0.
- DONE: Done=1 for one cycle, Busy=0, then IDLE.
- ERR: Err=1, Mem_MOV=0, In_Ready=0, Busy=0, then IDLE on the next cycle; Err stays set.
- Busy=1 in every state except IDLE, DONE and ERR.
- Count saturates at 2^AW.
- In_Ready=0 outside COLLECT.
- Latency with an ideal RAM (MOC the cycle after MOV, MOC low the cycle after MOV low), VERIFY=0: last byte taken → WRITE entry 1 cycle → MOC sampled cycle 2 → RELEASE → next COLLECT at cycle 4.

Test Plan:
- Byte mode, BaseAddr=0x000, stream 0x8A,0x00,0x12,0x34 (Last on 0x34), 1-cycle RAM → RAM[0..3] = 8A 00 12 34; Count=4; Done pulses once; Err=0.
- Word mode, BaseAddr=0x010, bytes DE AD BE EF 01 (Last on 01) → Mem_Data=0xDEADBEEF at 0x010, then 0x01000000 at 0x014; Count=2.
- Halfword mode, BaseAddr=0x003 → Err=1, ErrCode=01, no Mem_MOV pulse, In_Ready never high.
- RAM model holds MOC=0 forever, TIMEOUT=15 → Mem_MOV drops exactly 15 cycles after rising; ErrCode=10. A following Start clears Err.
- VERIFY=1, RAM corrupts bit 0 of the write at 0x020 (word 0xCAFEF00D) → ErrCode=11 after the read-back; Count=1.
- Byte mode, BaseAddr=0x1FF (AW=9), 2 bytes → second write lands at 0x000; Clr pulled low mid-WRITE → Mem_MOV=0 immediately, IDLE, all outputs 0.
